// File: rtl/nibble_pkg.sv
// Shared types and width helpers for the nibble-sum accumulator block.
package nibble_pkg;

  localparam int SUM_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Wide enough that COUNT full-scale sums cannot wrap.
  function automatic int acc_w(input int sum_w, input int count);
    return sum_w + $clog2(count);
  endfunction

endpackage

// File: rtl/nibble_sum_accum_if.sv
// Sum-in / block-total-out handshake bundle. NIBBLE_ACC_MAX_EN adds out_max.
interface nibble_sum_accum_if #(
  parameter int COUNT = 4,
  parameter int SUM_W = nibble_pkg::SUM_W_DEF
);
  localparam int ACC_W = nibble_pkg::acc_w(SUM_W, COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);

  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] in_sum;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
`ifdef NIBBLE_ACC_MAX_EN
  logic [SUM_W-1:0] out_max;

  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_max
  );
  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_max
  );
`else
  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_acc, out_count
  );
  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_acc, out_count
  );
`endif

endinterface

// File: rtl/nibble_out_reg.sv
// Result holding register: captures a payload on load and holds it until
// the downstream valid/ready handshake completes.
module nibble_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // Data is only written on load so it stays stable for the whole hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load && !r_valid) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/nibble_sum_accum.sv
// Accumulates COUNT nibble sums (or fewer on flush) into a block total.
// Optional running maximum output when NIBBLE_ACC_MAX_EN is defined.
module nibble_sum_accum
  import nibble_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  nibble_sum_accum_if.slave bus
);

  localparam int ACC_W = acc_w(SUM_W, COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);
`ifdef NIBBLE_ACC_MAX_EN
  localparam int MAX_W = SUM_W;
`else
  localparam int MAX_W = 0;
`endif
  localparam int PAY_W = ACC_W + CNT_W + MAX_W;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] w_acc_sum;
  logic [CNT_W-1:0] w_cnt_sum;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_close;
  logic             w_out_valid;
  logic [PAY_W-1:0] w_pay_in;
  logic [PAY_W-1:0] w_pay_out;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_close) w_state_nxt = HOLD;
               else if (w_accept) w_state_nxt = ACCUM;
      ACCUM:   if (w_close) w_state_nxt = HOLD;
      HOLD:    if (w_out_valid && bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Flush only closes a block that will hold at least one sample.
  always_comb begin
    w_in_ready = !rst && (r_state != HOLD);
    w_accept   = bus.in_valid && w_in_ready;
    w_close    = 1'b0;
    if (!rst && r_state != HOLD)
      w_close = (w_accept && r_cnt == CNT_W'(COUNT - 1)) ||
                (bus.flush && (r_state == ACCUM || w_accept));
  end

  assign w_acc_sum = r_acc + (w_accept ? ACC_W'(bus.in_sum) : '0);
  assign w_cnt_sum = r_cnt + CNT_W'(w_accept);

  always_ff @(posedge clk) begin
    if (rst || w_close) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_acc <= w_acc_sum;
      r_cnt <= w_cnt_sum;
    end
  end

`ifdef NIBBLE_ACC_MAX_EN
  logic [SUM_W-1:0] r_max;
  logic [SUM_W-1:0] w_max_nxt;

  assign w_max_nxt = (w_accept && bus.in_sum > r_max) ? bus.in_sum : r_max;

  always_ff @(posedge clk) begin
    if (rst || w_close) r_max <= '0;
    else                r_max <= w_max_nxt;
  end

  assign w_pay_in    = {w_acc_sum, w_cnt_sum, w_max_nxt};
  assign bus.out_max = w_pay_out[SUM_W-1:0];
`else
  assign w_pay_in = {w_acc_sum, w_cnt_sum};
`endif

  nibble_out_reg #(.W(PAY_W)) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_close),
    .i_data  (w_pay_in),
    .i_ready (bus.out_ready),
    .o_valid (w_out_valid),
    .o_data  (w_pay_out)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_acc   = w_pay_out[PAY_W-1 -: ACC_W];
  assign bus.out_count = w_pay_out[PAY_W-ACC_W-1 -: CNT_W];

endmodule

// File: doc/nibble_sum_accum.md
Name: nibble_sum_accum

Overview:
Downstream consumer of the 5-bit nibble-adder result (q). It accepts one sum per cycle over a valid/ready handshake and accumulates COUNT sums into a block total. It presents the total, with a sample count, on an output valid/ready handshake. Sits between the nibble adder and any reporting/display stage, turning a per-cycle sum stream into block totals.

Parameters:
COUNT, 4, number of sums per block; must be at least 2.
SUM_W, 5, width of each input sum; matches the nibble adder q width.
ACC_W, SUM_W+$clog2(COUNT), accumulator width; derived, never overridden; sized so COUNT*(2^SUM_W-1) cannot overflow.
CNT_W, $clog2(COUNT+1), width of the sample counter and out_count; derived.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  in_sum carries a valid sum this cycle.
in_ready  output  1  block can accept a sum this cycle.
in_sum  input  SUM_W  nibble sum from the adder.
flush  input  1  close the current block early; single-cycle pulse.
out_valid  output  1  out_acc/out_count are valid.
out_ready  input  1  downstream accepts the result.
out_acc  output  ACC_W  block total.
out_count  output  CNT_W  number of sums in the block (1..COUNT).

Behaviour:
- Reset: rst sampled high on a rising edge forces state IDLE, acc=0, cnt=0, out_valid=0, out_acc=0, out_count=0, in_ready=0 during that cycle. rst mid-block discards the partial sum; rst in HOLD drops out_valid with no handshake.
- States:
  - IDLE: cnt=0.
  - ACCUM: 0<cnt<COUNT.
  - HOLD: result presented.
- in_ready=1 in IDLE and ACCUM; 0 in HOLD and while rst=1. A sum is accepted when in_valid && in_ready.
- Accept, not closing: acc<=acc+zero-extended in_sum, cnt<=cnt+1, go ACCUM.
- Closing condition: accept with cnt==COUNT-1, or flush in ACCUM. On closing:
  - out_acc<=acc+(accepted ? in_sum : 0).
  - out_count<=cnt+(accepted ? 1 : 0).
  - out_valid<=1, acc<=0, cnt<=0, go HOLD.
  - Latency: out_valid is high the cycle after the closing edge.
- flush and accept on the same edge: the sum is included, then the block closes.
- flush in IDLE with no accept: ignored; zero-count blocks are never emitted.
- flush in IDLE with an accept: closes a 1-sample block.
- flush in HOLD: ignored.
- HOLD:
  - out_acc, out_count and out_valid stay stable until out_valid && out_ready.
  - On that edge: out_valid<=0, go IDLE.
  - in_ready returns high the following cycle; there is no same-cycle bypass.
- All arithmetic is unsigned. in_sum is zero-extended to ACC_W.

Optional Feature:
NIBBLE_ACC_MAX_EN
- Defined:
  - Adds output out_max [SUM_W] holding the largest in_sum accepted in the block.
  - out_max is captured with out_acc and follows the same stability and reset rules (reset value 0).
  - Running max resets to 0 at block close.
- Undefined: port and logic absent; all other behaviour is identical.

Decomposition:
- Shared package nibble_pkg:
  - SUM_W default.
  - State enum (IDLE, ACCUM, HOLD).
  - Function computing ACC_W from SUM_W and COUNT.
- One sub-module, nibble_out_reg: output holding register with valid/ready hold logic, parameterised on payload width. It holds out_acc, out_count and optionally out_max.
- Accumulator and FSM stay in the top module.

Test Plan:
- Full block (COUNT=4, out_ready=1): sums 5,12,27,31 on consecutive cycles -> out_acc=75, out_count=4, out_valid=1 one cycle after the 4th accept, in_ready=0 that cycle.
- Max total: four sums of 31 -> out_acc=124 (7'h7C), no wrap; the next block starts from 0.
- Backpressure: out_ready=0 for 5 cycles after close -> out_acc/out_count stable, in_ready=0 throughout. Raise out_ready -> out_valid drops next cycle, in_ready=1 the cycle after.
- Flush:
  - Sums 9,6 accepted, then flush alone -> out_acc=15, out_count=2.
  - flush together with in_sum=3 on the 3rd accept -> out_acc=18, out_count=3.
  - flush in IDLE with in_valid=0 -> no out_valid.
- Reset mid-block: sums 10,10 accepted, rst=1 for one cycle -> all outputs 0. Then sums 1,1,1,1 -> out_acc=4.
- NIBBLE_ACC_MAX_EN defined: sums 7,30,2,19 -> out_max=30, out_acc=58.
